// File: rtl/segasys1_pkg.sv
// segasys1_pkg: shared register map, status bit layout and register decode
// for the System 1 I/O controller.
`timescale 1ns/1ps
package segasys1_pkg;

    // I/O register addresses (low address byte)
    localparam logic [7:0] ADDR_SND_A = 8'h14;
    localparam logic [7:0] ADDR_SND_B = 8'h18;
    localparam logic [7:0] ADDR_VID_A = 8'h15;
    localparam logic [7:0] ADDR_VID_B = 8'h19;
    localparam logic [7:0] ADDR_STAT  = 8'h1A;

    // Status register layout: {OVF, FULL, 0, count[4:0]}
    localparam int STAT_OVF_BIT  = 7;
    localparam int STAT_FULL_BIT = 6;
    localparam int STAT_CNT_MSB  = 4;
    localparam int STAT_CNT_LSB  = 0;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_SND  = 2'd1,
        REG_VID  = 2'd2,
        REG_STAT = 2'd3
    } reg_sel_e;

    // Map an address onto the register it hits; status only exists when enabled.
    function automatic reg_sel_e reg_decode(input logic [7:0] addr, input logic stat_en);
        reg_sel_e sel;
        case (addr)
            ADDR_SND_A, ADDR_SND_B: sel = REG_SND;
            ADDR_VID_A, ADDR_VID_B: sel = REG_VID;
            ADDR_STAT:              sel = stat_en ? REG_STAT : REG_NONE;
            default:                sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/segasys1_cmdfifo.sv
// segasys1_cmdfifo: small power-of-two FIFO carrying sound commands.
// A pop while empty is ignored; a push while full only succeeds when a pop
// frees the slot on the same edge. The head entry reads as zero when empty.
`timescale 1ns/1ps
module segasys1_cmdfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK48M,
    input  logic                     RESET_N,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign pop_ok_s  = pop & ~empty_s;
    // A pop on the same edge frees a slot, so a full queue still accepts the push.
    assign push_ok_s = push & (~full_s | pop_ok_s);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge CLK48M) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry, forced to zero while the queue is empty.
    always_comb begin
        if (empty_s) begin
            dout = {WIDTH{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/segasys1_ioctl.sv
// segasys1_ioctl: System 1 I/O decode -- input/DSW port mux, video mode latch
// and sound command queue. Defining SEGASYS1_IOCTL_STATUS_EN adds a readable
// status register at 0x1A with a sticky overflow flag.
`timescale 1ns/1ps
module segasys1_ioctl
    import segasys1_pkg::*;
#(
    parameter int NPORT        = 5,
    parameter int SQ_DEPTH     = 4,
    parameter int LEGACY_ALIAS = 1
) (
    input  logic               CLK48M,
    input  logic               RESET_N,
    input  logic [7:0]         CPUAD,
    input  logic               IORQ,
    input  logic               RD,
    input  logic               WR,
    input  logic [7:0]         CPUDO,
    input  logic [NPORT*8-1:0] INP,
    output logic [7:0]         IODO,
    output logic               IODV,
    output logic [7:0]         VIDMD,
    output logic [7:0]         SNDNO,
    output logic               SNDRQ,
    input  logic               SNDACK
);
    localparam int SQ_AW = $clog2(SQ_DEPTH);
`ifdef SEGASYS1_IOCTL_STATUS_EN
    localparam logic STAT_EN = 1'b1;
`else
    localparam logic STAT_EN = 1'b0;
`endif

    logic           wr_lvl_s;
    logic           rd_lvl_s;
    logic           wr_idle_r;
    logic           rd_idle_r;
    logic           wr_evt_s;
    logic           rd_evt_s;
    reg_sel_e       reg_sel_s;
    logic [2:0]     port_idx_s;
    logic           port_hit_s;
    logic [7:0]     port_data_s;
    logic [7:0]     iodo_s;
    logic           iodv_s;
    logic [7:0]     vidmd_r;
    logic           snd_push_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [SQ_AW:0] fifo_count_s;
    logic [7:0]     fifo_dout_s;

    assign wr_lvl_s  = IORQ & WR;
    assign rd_lvl_s  = IORQ & RD;
    // The idle flags only become set after a cycle with the strobe low, so a
    // strobe already held through reset release never looks like a new edge.
    assign wr_evt_s  = wr_lvl_s & wr_idle_r;
    assign rd_evt_s  = rd_lvl_s & rd_idle_r;
    assign reg_sel_s = reg_decode(CPUAD, STAT_EN);
    assign snd_push_s = wr_evt_s & (reg_sel_s == REG_SND);

    // Edge detect: remember whether each strobe was low on the previous edge.
    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_idle_r <= 1'b0;
            rd_idle_r <= 1'b0;
        end else begin
            wr_idle_r <= ~wr_lvl_s;
            rd_idle_r <= ~rd_lvl_s;
        end
    end

    // Video mode latch, loaded once per write cycle to 0x15/0x19.
    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            vidmd_r <= 8'h00;
        end else if (wr_evt_s && (reg_sel_s == REG_VID)) begin
            vidmd_r <= CPUDO;
        end else begin
            vidmd_r <= vidmd_r;
        end
    end

    // Port select from CPUAD[4:2]; registers win, legacy alias maps 0x0D-style to port 4.
    always_comb begin
        port_idx_s = CPUAD[4:2];
        port_hit_s = 1'b0;
        if (reg_sel_s != REG_NONE) begin
            port_hit_s = 1'b0;
        end else if ((LEGACY_ALIAS != 0) && (NPORT > 4) && (CPUAD[4:2] == 3'd3) && CPUAD[0]) begin
            port_idx_s = 3'd4;
            port_hit_s = 1'b1;
        end else if (int'(CPUAD[4:2]) < NPORT) begin
            port_hit_s = 1'b1;
        end else begin
            port_hit_s = 1'b0;
        end
    end

    // Byte of the selected input port.
    always_comb begin
        port_data_s = 8'hFF;
        for (int k = 0; k < NPORT; k++) begin
            port_data_s = (port_idx_s == 3'(k)) ? INP[k*8 +: 8] : port_data_s;
        end
    end

`ifdef SEGASYS1_IOCTL_STATUS_EN
    logic       ovf_r;
    logic       drop_s;
    logic [7:0] status_s;

    // A push into a full queue without a same-edge ack is dropped.
    assign drop_s = snd_push_s & fifo_full_s & ~SNDACK;

    // Sticky overflow; a drop on the same edge as a status read wins.
    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (rd_evt_s && (reg_sel_s == REG_STAT)) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Assemble the status byte from the queue state.
    always_comb begin
        status_s = 8'h00;
        status_s[STAT_OVF_BIT]  = ovf_r;
        status_s[STAT_FULL_BIT] = fifo_full_s;
        status_s[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(fifo_count_s);
    end
`else
    logic unused_stat_s;
    assign unused_stat_s = ^{rd_evt_s, fifo_full_s, fifo_count_s};
`endif

    // Read data selector for the current bus cycle; 0xFF whenever nothing is selected.
    always_comb begin
        iodv_s = 1'b0;
        iodo_s = 8'hFF;
        if (IORQ) begin
            case (reg_sel_s)
                REG_VID: begin
                    iodv_s = 1'b1;
                    iodo_s = vidmd_r;
                end
`ifdef SEGASYS1_IOCTL_STATUS_EN
                REG_STAT: begin
                    iodv_s = 1'b1;
                    iodo_s = status_s;
                end
`endif
                REG_SND: begin
                    iodv_s = 1'b0;
                    iodo_s = 8'hFF;
                end
                default: begin
                    if (port_hit_s) begin
                        iodv_s = 1'b1;
                        iodo_s = port_data_s;
                    end else begin
                        iodv_s = 1'b0;
                        iodo_s = 8'hFF;
                    end
                end
            endcase
        end else begin
            iodv_s = 1'b0;
            iodo_s = 8'hFF;
        end
    end

    segasys1_cmdfifo #(
        .DEPTH (SQ_DEPTH),
        .WIDTH (8)
    ) u_cmdfifo (
        .CLK48M  (CLK48M),
        .RESET_N (RESET_N),
        .push    (snd_push_s),
        .pop     (SNDACK),
        .din     (CPUDO),
        .dout    (fifo_dout_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign IODO  = iodo_s;
    assign IODV  = iodv_s;
    assign VIDMD = vidmd_r;
    assign SNDNO = fifo_dout_s;
    assign SNDRQ = ~fifo_empty_s;

endmodule

// File: tb/tb_segasys1_ioctl.sv
// tb_segasys1_ioctl: directed and randomized bus traffic against a queue-based
// reference model of the I/O controller, compared on every falling edge.
`timescale 1ns/1ps
module tb_segasys1_ioctl;

    localparam int NPORT = 5;
    localparam int SQD   = 4;
    localparam bit LEG   = 1'b1;
`ifdef SEGASYS1_IOCTL_STATUS_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  b_addr;
    logic        b_iorq;
    logic        b_rd;
    logic        b_wr;
    logic [7:0]  b_do;
    logic [39:0] inp;
    logic        snd_ack;
    logic [7:0]  IODO;
    logic        IODV;
    logic [7:0]  VIDMD;
    logic [7:0]  SNDNO;
    logic        SNDRQ;

    // reference model state
    logic [7:0]  mq[$];
    logic [7:0]  m_vid;
    bit          m_ovf;
    bit          new_cyc;
    bit          cmp_en;
    bit          rand_ack_en;
    int          ack_div;
    int          n_checks;
    int          n_errors;

    always #5 clk = ~clk;

    segasys1_ioctl #(.NPORT(NPORT), .SQ_DEPTH(SQD), .LEGACY_ALIAS(1)) dut (
        .CLK48M (clk),
        .RESET_N(rst_n),
        .CPUAD  (b_addr),
        .IORQ   (b_iorq),
        .RD     (b_rd),
        .WR     (b_wr),
        .CPUDO  (b_do),
        .INP    (inp),
        .IODO   (IODO),
        .IODV   (IODV),
        .VIDMD  (VIDMD),
        .SNDNO  (SNDNO),
        .SNDRQ  (SNDRQ),
        .SNDACK (snd_ack)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_vid   = 8'h00;
        m_ovf   = 1'b0;
        new_cyc = 1'b0;
    endtask

    // What one rising edge does, from the bus-cycle point of view.
    task automatic model_edge();
        if (rst_n) begin
            if (snd_ack && mq.size() > 0) void'(mq.pop_front());
            if (new_cyc && b_iorq) begin
                if (b_wr) begin
                    if (b_addr == 8'h15 || b_addr == 8'h19) m_vid = b_do;
                    else if (b_addr == 8'h14 || b_addr == 8'h18) begin
                        if (mq.size() < SQD) mq.push_back(b_do);
                        else m_ovf = 1'b1;
                    end
                end else if (b_rd && b_addr == 8'h1A && STAT_EN) begin
                    m_ovf = 1'b0;
                end
            end
            new_cyc = 1'b0;
        end
    endtask

    // Expected read data for the address currently on the bus.
    function automatic void exp_read(input logic [7:0] a, input logic iorq,
                                     output logic dv, output logic [7:0] d);
        int p;
        dv = 1'b0;
        d  = 8'hFF;
        p  = int'(a[4:2]);
        if (iorq) begin
            if (a == 8'h15 || a == 8'h19) begin
                dv = 1'b1;
                d  = m_vid;
            end else if (a == 8'h14 || a == 8'h18) begin
                dv = 1'b0;
            end else if (a == 8'h1A && STAT_EN) begin
                dv = 1'b1;
                d  = {m_ovf, (mq.size() == SQD), 1'b0, 5'(mq.size())};
            end else begin
                if (LEG && p == 3 && a[0]) p = 4;
                if (p < NPORT) begin
                    dv = 1'b1;
                    d  = inp[p*8 +: 8];
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        if (rand_ack_en) snd_ack = ($urandom_range(0, ack_div) == 0);
        else snd_ack = 1'b0;
    endtask

    task automatic bus(input bit is_wr, input logic [7:0] a, input logic [7:0] d, input int hold);
        b_addr = a; b_do = d; b_iorq = 1'b1; b_wr = is_wr; b_rd = ~is_wr; new_cyc = 1'b1;
        repeat (hold) tick();
        b_iorq = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
        tick();
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] ed, input logic ev, input string nm);
        b_addr = a; b_iorq = 1'b1; b_rd = 1'b1; b_wr = 1'b0; new_cyc = 1'b1;
        #1;
        chk({nm, " data"}, IODO, ed);
        chk({nm, " valid"}, {7'd0, IODV}, {7'd0, ev});
        tick(); tick();
        b_iorq = 1'b0; b_rd = 1'b0;
        tick();
    endtask

    task automatic ack_once();
        snd_ack = 1'b1;
        tick();
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic       e_dv;
        logic [7:0] e_d;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                exp_read(b_addr, b_iorq, e_dv, e_d);
                chk("cyc iodv", {7'd0, IODV}, {7'd0, e_dv});
                chk("cyc iodo", IODO, e_d);
                chk("cyc vidmd", VIDMD, m_vid);
                chk("cyc sndno", SNDNO, (mq.size() > 0) ? mq[0] : 8'h00);
                chk("cyc sndrq", {7'd0, SNDRQ}, {7'd0, (mq.size() > 0)});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        logic [7:0]  ra;
        int          op;
        n_checks = 0; n_errors = 0; cmp_en = 1'b0; rand_ack_en = 1'b0; ack_div = 2;
        b_addr = 8'h00; b_iorq = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_do = 8'h00;
        snd_ack = 1'b0; inp = 40'h11_22_33_44_55;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset vidmd", VIDMD, 8'h00);
        chk("reset sndno", SNDNO, 8'h00);
        chk("reset sndrq", {7'd0, SNDRQ}, 8'h00);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) tick();

        // input ports, alias and an unmapped address
        rd_chk(8'h00, 8'h55, 1'b1, "port0");
        rd_chk(8'h04, 8'h44, 1'b1, "port1");
        rd_chk(8'h08, 8'h33, 1'b1, "port2");
        rd_chk(8'h0C, 8'h22, 1'b1, "port3");
        rd_chk(8'h0D, 8'h11, 1'b1, "alias port4");
        rd_chk(8'h1F, 8'hFF, 1'b0, "unmapped 1F");
        rd_chk(8'h14, 8'hFF, 1'b0, "sndq not readable");

        // video mode latch
        b_addr = 8'h19; b_do = 8'hA5; b_iorq = 1'b1; b_wr = 1'b1; new_cyc = 1'b1;
        #1 chk("vidmd before edge", VIDMD, 8'h00);
        tick();
        #1 chk("vidmd after edge", VIDMD, 8'hA5);
        tick();
        b_iorq = 1'b0; b_wr = 1'b0;
        tick();
        rd_chk(8'h15, 8'hA5, 1'b1, "vidmd read");

        // three commands, three acks
        bus(1'b1, 8'h14, 8'h01, 2);
        bus(1'b1, 8'h14, 8'h02, 2);
        bus(1'b1, 8'h14, 8'h03, 2);
        #1 chk("snd seq 1", SNDNO, 8'h01);
        ack_once(); #1 chk("snd seq 2", SNDNO, 8'h02);
        ack_once(); #1 chk("snd seq 3", SNDNO, 8'h03);
        ack_once(); #1 chk("snd drained rq", {7'd0, SNDRQ}, 8'h00);
        chk("snd drained no", SNDNO, 8'h00);

        // overflow: fifth write dropped
        for (int i = 0; i < 5; i++) bus(1'b1, 8'h18, 8'(8'h50 + i), 1);
        #1 chk("ovf head", SNDNO, 8'h50);
        if (STAT_EN) begin
            rd_chk(8'h1A, 8'hC4, 1'b1, "status ovf");
            rd_chk(8'h1A, 8'h44, 1'b1, "status cleared");
        end else begin
            rd_chk(8'h1A, 8'hFF, 1'b0, "no status reg");
        end
        for (int i = 0; i < 4; i++) begin
            #1 chk("ovf drain", SNDNO, 8'(8'h50 + i));
            ack_once();
        end
        #1 chk("ovf drained rq", {7'd0, SNDRQ}, 8'h00);

        // full queue, write coincident with ack
        for (int i = 0; i < 4; i++) bus(1'b1, 8'h14, 8'(8'hA0 + i), 1);
        snd_ack = 1'b1;
        bus(1'b1, 8'h14, 8'hB4, 2);
        if (STAT_EN) rd_chk(8'h1A, 8'h44, 1'b1, "full push+pop count");
        #1 chk("wrap head", SNDNO, 8'hA1);
        ack_once(); #1 chk("wrap 2", SNDNO, 8'hA2);
        ack_once(); #1 chk("wrap 3", SNDNO, 8'hA3);
        ack_once(); #1 chk("wrap tail", SNDNO, 8'hB4);
        chk("wrap rq", {7'd0, SNDRQ}, 8'h01);
        ack_once(); #1 chk("wrap empty", {7'd0, SNDRQ}, 8'h00);

        // reset during a held write, still held after release
        b_addr = 8'h14; b_do = 8'h77; b_iorq = 1'b1; b_wr = 1'b1; new_cyc = 1'b1;
        tick();
        #1 chk("held push", SNDNO, 8'h77);
        rst_n = 1'b0;
        model_reset();
        #1 chk("async clr rq", {7'd0, SNDRQ}, 8'h00);
        chk("async clr vid", VIDMD, 8'h00);
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        #1 chk("held no push", {7'd0, SNDRQ}, 8'h00);
        b_iorq = 1'b0; b_wr = 1'b0;
        repeat (2) tick();

        // randomized traffic
        rand_ack_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ack_div = (i < 200) ? 6 : 2;
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) begin
                rnd = {$urandom(), $urandom()};
                inp = rnd[39:0];
            end
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 31));
            case (op)
                0, 1, 2, 3: bus(1'b1, ($urandom_range(0, 1) == 0) ? 8'h14 : 8'h18,
                                8'($urandom()), $urandom_range(1, 3));
                4:          bus(1'b1, ($urandom_range(0, 1) == 0) ? 8'h15 : 8'h19,
                                8'($urandom()), $urandom_range(1, 3));
                5:          bus(1'b1, ra, 8'($urandom()), $urandom_range(1, 2));
                6, 7:       bus(1'b0, ra, 8'h00, $urandom_range(1, 3));
                default:    repeat ($urandom_range(1, 4)) tick();
            endcase
        end
        rand_ack_en = 1'b0;
        repeat (2) tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
